// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WRITE
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    function automatic int unsigned clks_per_bit(input logic [31:0] freq, input logic [31:0] baud);
        return int'(freq / baud);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and 3-sample majority voter.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall,
    output logic maj
);
    logic [1:0] sync_q;
    logic [1:0] hist_q;
    logic       din_s;

    assign din_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
            hist_q <= {hist_q[0], din_s};
        end
    end

    // Evaluated at the decision point: hist_q[1], hist_q[0], din_s are the three samples.
    assign fall = hist_q[0] & ~din_s;
    assign maj  = (hist_q[1] & hist_q[0]) | (hist_q[1] & din_s) | (hist_q[0] & din_s);

endmodule

// File: rtl/uart_receiver.sv
// Parametrised UART receive engine feeding a FIFO write port.
// Optional break detection (brk output) enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8,
    parameter logic [1:0]  PARITY_MODE     = 2'd0,
    parameter logic [31:0] STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  full,
    output logic                  we,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                  brk
`endif
);
    localparam int unsigned CPB  = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned BW   = $clog2(CPB);
    localparam int unsigned DW   = $clog2(WORD_WIDTH + 1);

    localparam logic [BW-1:0] DEC_CNT   = BW'(HALF + 1);
    localparam logic [BW-1:0] LAST_CNT  = BW'(CPB - 1);
    localparam logic [DW-1:0] LAST_DATA = DW'(WORD_WIDTH - 32'd1);

    if (PARITY_MODE == 2'd3 || CPB < 4 || WORD_WIDTH < 5 || WORD_WIDTH > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_cfg_err
        $error("uart_receiver: illegal parameter combination");
    end

    logic fall, maj;

    uart_rx_sampler u_sampler (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .fall (fall),
        .maj  (maj)
    );

    rx_state_t             state;
    logic [BW-1:0]         bit_cnt;
    logic [DW-1:0]         data_cnt;
    logic                  stop_cnt;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] dout_q;
    logic                  parity_err_q;
    logic                  frame_err_q;
    logic                  last_stop;
    logic                  at_dec;
    logic                  at_last;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  zero_q;
    logic                  brk_q;
`endif

    assign last_stop = (STOP_BITS == 32'd1) || stop_cnt;
    assign at_dec    = (bit_cnt == DEC_CNT);
    assign at_last   = (bit_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            data_cnt     <= '0;
            stop_cnt     <= 1'b0;
            shift_q      <= '0;
            dout_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q       <= 1'b0;
            brk_q        <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                WRITE: begin
                    if (!full) dout_q <= shift_q;
                    // A start edge landing in the write cycle is taken straight away.
                    bit_cnt <= '0;
                    if (fall) state <= START;
                    else      state <= IDLE;
                end
                default: begin
                    bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
                    case (state)
                        START: begin
                            if (at_dec && maj) state <= IDLE;
                            if (at_last) begin
                                state        <= DATA;
                                data_cnt     <= '0;
                                parity_err_q <= 1'b0;
                                frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                                zero_q       <= 1'b1;
`endif
                            end
                        end
                        DATA: begin
                            if (at_dec) begin
                                shift_q <= {maj, shift_q[WORD_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                                if (maj) zero_q <= 1'b0;
`endif
                            end
                            if (at_last) begin
                                if (data_cnt == LAST_DATA) begin
                                    stop_cnt <= 1'b0;
                                    if (PARITY_MODE != PARITY_NONE) state <= PARITY;
                                    else                            state <= STOP;
                                end else begin
                                    data_cnt <= data_cnt + 1'b1;
                                end
                            end
                        end
                        PARITY: begin
                            if (at_dec) begin
                                parity_err_q <= ((^shift_q) ^ maj) != (PARITY_MODE == PARITY_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                                if (maj) zero_q <= 1'b0;
`endif
                            end
                            if (at_last) begin
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end
                        STOP: begin
                            if (at_dec) begin
                                frame_err_q <= frame_err_q | ~maj;
                                // Leave at the decision point so a back-to-back start edge is seen.
                                if (last_stop) begin
`ifdef UART_RX_BREAK_DETECT_EN
                                    if (zero_q && !maj) begin
                                        brk_q <= 1'b1;
                                        state <= IDLE;
                                    end else begin
                                        state <= WRITE;
                                    end
`else
                                    state <= WRITE;
`endif
                                end
                            end
                            if (at_last) stop_cnt <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            endcase
        end
    end

    assign we         = (state == WRITE) && !full;
    assign overrun    = (state == WRITE) && full;
    assign dout       = we ? shift_q : dout_q;
    assign parity_err = we & parity_err_q;
    assign frame_err  = we & frame_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign brk        = brk_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three configurations (8N1, 8E1, 7O2) at 10 clk/bit, frame-level model.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic full = 1'b0;
    logic din0 = 1'b1, din1 = 1'b1, din2 = 1'b1;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic we0, we1, we2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
`ifdef UART_RX_BREAK_DETECT_EN
    logic brk0, brk1, brk2;
`endif

    always #5 clk = ~clk;

    uart_receiver #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000), .WORD_WIDTH(32'd8),
                    .PARITY_MODE(2'd0), .STOP_BITS(32'd1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .din(din0), .dout(dout0), .full(full), .we(we0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
`ifdef UART_RX_BREAK_DETECT_EN
        , .brk(brk0)
`endif
    );
    uart_receiver #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000), .WORD_WIDTH(32'd8),
                    .PARITY_MODE(2'd2), .STOP_BITS(32'd1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .dout(dout1), .full(full), .we(we1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
`ifdef UART_RX_BREAK_DETECT_EN
        , .brk(brk1)
`endif
    );
    uart_receiver #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000), .WORD_WIDTH(32'd7),
                    .PARITY_MODE(2'd1), .STOP_BITS(32'd2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .dout(dout2), .full(full), .we(we2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2)
`ifdef UART_RX_BREAK_DETECT_EN
        , .brk(brk2)
`endif
    );

    typedef struct {
        int         idx;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        int         idx;
        logic [8:0] d;
        logic       bad_par;
        logic [1:0] stops;   // per stop bit: 1 = sent high
    } vec_t;

    rec_t rq[$];
    int   ovc[3];
    int   brkc[3];
    int   nvec = 0;
    int   nmis = 0;

    // Monitor: every write strobe cycle is one record; overrun/brk cycles are counted.
    always @(negedge clk) begin
        if (we0) rq.push_back('{0, {1'b0, dout0}, pe0, fe0});
        if (we1) rq.push_back('{1, {1'b0, dout1}, pe1, fe1});
        if (we2) rq.push_back('{2, {2'b0, dout2}, pe2, fe2});
        if (ov0) ovc[0]++;
        if (ov1) ovc[1]++;
        if (ov2) ovc[2]++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk0) brkc[0]++;
        if (brk1) brkc[1]++;
        if (brk2) brkc[2]++;
`endif
    end

    function automatic int wid(input int i);  return (i == 2) ? 7 : 8; endfunction
    function automatic int pmode(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
    function automatic int nstop(input int i); return (i == 2) ? 2 : 1; endfunction
    function automatic logic [8:0] mask(input int i); return (i == 2) ? 9'h07F : 9'h0FF; endfunction

    function automatic logic pbit(input int i, input logic [8:0] d, input logic bad);
        logic x;
        x = ^(d & mask(i));
        return ((pmode(i) == 2) ? x : ~x) ^ bad;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
    endtask

    task automatic hold_cyc(input int idx, input logic v, input int n);
        drive(idx, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input logic bad_par,
                              input logic [1:0] stops);
        hold_cyc(idx, 1'b0, 10);
        for (int b = 0; b < wid(idx); b++) hold_cyc(idx, d[b], 10);
        if (pmode(idx) != 0) hold_cyc(idx, pbit(idx, d, bad_par), 10);
        for (int s = 0; s < nstop(idx); s++) hold_cyc(idx, stops[s], 10);
        hold_cyc(idx, 1'b1, 20);
    endtask

    logic [8:0] last0 = '0;

    task automatic run_frame(input vec_t v);
        int   base, b0;
        logic exp_pe, exp_fe, all_stop0, is_brk;
        rec_t r;
        base = rq.size();
        b0   = brkc[v.idx];
        send_frame(v.idx, v.d, v.bad_par, v.stops);
        exp_pe    = (pmode(v.idx) != 0) && v.bad_par;
        all_stop0 = (nstop(v.idx) == 1) ? !v.stops[0] : (v.stops == 2'b00);
        exp_fe    = (nstop(v.idx) == 1) ? !v.stops[0] : (v.stops != 2'b11);
        is_brk    = (v.d == 0) && all_stop0 && (pmode(v.idx) == 0 || !pbit(v.idx, v.d, v.bad_par));
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_pulses", brkc[v.idx] - b0, is_brk ? 1 : 0);
`else
        is_brk = 1'b0;
        chk("brk_cnt_idle", brkc[v.idx] - b0, 0);
`endif
        if (is_brk) begin
            chk("writes_on_break", rq.size() - base, 0);
        end else begin
            chk("write_count", rq.size() - base, 1);
            if (rq.size() > base) begin
                r = rq[base];
                chk("write_lane", r.idx, v.idx);
                chk("dout", r.d, v.d);
                chk("parity_err", r.pe, exp_pe);
                chk("frame_err", r.fe, exp_fe);
                if (v.idx == 0) last0 = v.d;
            end
        end
    endtask

    initial begin
        vec_t vt[40];
        int   base, o0, b0;
        rec_t r;

        vt[0] = '{0, 9'h0A5, 1'b0, 2'b11};  // 8N1 clean
        vt[1] = '{1, 9'h003, 1'b1, 2'b11};  // 8E1, parity bit sent as 1
        vt[2] = '{2, 9'h055, 1'b0, 2'b11};  // 7O2 clean
        vt[3] = '{0, 9'h081, 1'b0, 2'b10};  // stop bit low
        vt[4] = '{0, 9'h07E, 1'b0, 2'b11};
        for (int i = 5; i < 40; i++) begin
            vt[i].idx     = int'($urandom_range(0, 2));
            vt[i].d       = 9'($urandom) & mask(vt[i].idx);
            vt[i].bad_par = ($urandom_range(0, 3) == 0);
            vt[i].stops   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", we0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_parity_err", pe0, 0);
        chk("rst_frame_err", fe0, 0);
        chk("rst_overrun", ov0, 0);
        rst_n = 1'b1;
        hold_cyc(0, 1'b1, 20);

        for (int i = 0; i < 40; i++) run_frame(vt[i]);

        // Glitch shorter than half a bit: no activity, then a good frame.
        base = rq.size();
        o0   = ovc[0];
        hold_cyc(0, 1'b0, 3);
        hold_cyc(0, 1'b1, 200);
        chk("glitch_writes", rq.size() - base, 0);
        chk("glitch_overrun", ovc[0] - o0, 0);
        run_frame('{0, 9'h03C, 1'b0, 2'b11});

        // Overrun: FIFO full through the whole frame.
        base = rq.size();
        o0   = ovc[0];
        full = 1'b1;
        send_frame(0, 9'h011, 1'b0, 2'b11);
        chk("overrun_pulses", ovc[0] - o0, 1);
        chk("overrun_writes", rq.size() - base, 0);
        chk("overrun_dout_held", dout0, last0);
        full = 1'b0;

        // Break: line low for 15 bit times, released, must not retrigger while low.
        base = rq.size();
        b0   = brkc[0];
        o0   = ovc[0];
        hold_cyc(0, 1'b0, 150);
        hold_cyc(0, 1'b1, 30);
        chk("break_overrun", ovc[0] - o0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break_brk", brkc[0] - b0, 1);
        chk("break_writes", rq.size() - base, 0);
`else
        chk("break_brk", brkc[0] - b0, 0);
        chk("break_writes", rq.size() - base, 1);
        if (rq.size() > base) begin
            r = rq[base];
            chk("break_dout", r.d, 0);
            chk("break_frame_err", r.fe, 1);
            chk("break_parity_err", r.pe, 0);
            last0 = '0;
        end
`endif
        run_frame('{0, 9'h05A, 1'b0, 2'b11});

        // Reset in the middle of DATA: outputs clear immediately, next frame is clean.
        hold_cyc(0, 1'b0, 10);
        hold_cyc(0, 1'b0, 10);
        hold_cyc(0, 1'b1, 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout0, 0);
        chk("midrst_we", we0, 0);
        chk("midrst_frame_err", fe0, 0);
        din0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_cyc(0, 1'b1, 20);
        run_frame('{0, 9'h042, 1'b0, 2'b11});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
